// File: rtl/dummy_accelerator_lat_cu.sv
// dummy_accelerator_lat_cu: in-order latency control unit with DEPTH in-flight slots
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               synchronous drop of every in-flight operation
//   valid_i/ready_o       upstream issue handshake; lat_i and data_i describe the operation
//   valid_o/ready_i       downstream result handshake; data_o carries the result
//   count_o, busy_o       occupied slots and "any slot occupied"
module dummy_accelerator_lat_cu #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int LAT_W  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [LAT_W-1:0]           lat_i,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [DATA_W-1:0]          data_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       busy_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [LAT_W-1:0]  r_rem  [DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic w_empty, w_full, w_lat0, w_bypass, w_head_valid, w_push, w_pop;
   always_comb begin
      w_empty      = r_count == '0;
      w_full       = r_count == CW'(DEPTH);
      w_lat0       = lat_i == '0;
      // zero-latency op into an empty buffer goes straight through without a slot
      w_bypass     = w_empty && w_lat0 && valid_i && !flush_i;
      w_head_valid = !w_empty && r_rem[r_rd_ptr] == '0;
      ready_o      = !flush_i && !w_full && (w_empty && w_lat0 ? ready_i : 1'b1);
      valid_o      = !flush_i && (w_head_valid || w_bypass);
      data_o       = w_bypass ? data_i : r_data[r_rd_ptr];
      w_push       = valid_i && ready_o && !(w_empty && w_lat0);
      w_pop        = !flush_i && w_head_valid && ready_i;
   end
   assign count_o = r_count;
   assign busy_o  = !w_empty;
   // free slots keep counting down too; their value is overwritten on the next write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= '0;
            r_rem[i]  <= '0;
         end
      end else begin
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && r_wr_ptr == PW'(i)) begin
               r_data[i] <= data_i;
               r_rem[i]  <= w_lat0 ? '0 : lat_i - 1'b1;
            end else if (r_rem[i] != '0) begin
               r_rem[i] <= r_rem[i] - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_dummy_accelerator_lat_cu.sv
// tb_dummy_accelerator_lat_cu: directed and random checks against a due-time queue model
module tb_dummy_accelerator_lat_cu;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LW    = 4;
   localparam int CW    = $clog2(DEPTH+1);
   logic          clk_i   = 1'b0;
   logic          rst_ni  = 1'b0;
   logic          flush_i = 1'b0;
   logic [LW-1:0] lat_i   = '0;
   logic [DW-1:0] data_i  = '0;
   logic          valid_i = 1'b0;
   logic          ready_i = 1'b1;
   logic          ready_o, valid_o, busy_o;
   logic [DW-1:0] data_o;
   logic [CW-1:0] count_o;
   dummy_accelerator_lat_cu #(.DATA_W(DW), .DEPTH(DEPTH), .LAT_W(LW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .lat_i(lat_i), .data_i(data_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
      .ready_i(ready_i), .count_o(count_o), .busy_o(busy_o)
   );
   always #5 clk_i = ~clk_i;
   typedef struct {
      logic [DW-1:0] d;
      int            due;
   } item_t;
   item_t q[$];
   int cyc    = 0;
   int n_vec  = 0;
   int n_err  = 0;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask
   // one clock: drive, check against the model, then advance the model at the edge
   task automatic step(input bit v, input int lat, input logic [DW-1:0] d, input bit rdy, input bit fl);
      bit byp, ev, er, pop, push;
      logic [DW-1:0] ed;
      int due;
      @(negedge clk_i);
      valid_i = v;
      lat_i   = LW'(lat);
      data_i  = d;
      ready_i = rdy;
      flush_i = fl;
      #1;
      byp = q.size() == 0 && lat == 0 && v && !fl;
      ev  = !fl && (byp || (q.size() > 0 && cyc >= q[0].due));
      ed  = byp ? d : (q.size() > 0 ? q[0].d : '0);
      er  = !fl && q.size() < DEPTH && ((q.size() == 0 && lat == 0) ? rdy : 1'b1);
      check("ready_o", 64'(ready_o), 64'(er));
      check("valid_o", 64'(valid_o), 64'(ev));
      check("count_o", 64'(count_o), 64'(q.size()));
      check("busy_o", 64'(busy_o), 64'(q.size() != 0));
      if (ev) check("data_o", 64'(data_o), 64'(ed));
      pop  = ev && rdy && !byp;
      push = v && er && !byp;
      due  = cyc + (lat == 0 ? 1 : lat);
      @(posedge clk_i);
      cyc++;
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{d, due});
      end
   endtask
   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1, '0, rdy, 1'b0);
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, 64'(count_o), 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_valid"}, 64'(valid_o), 64'd0);
      check({tag, "_data"}, 64'(data_o), 64'd0);
      check({tag, "_ready"}, 64'(ready_o), 64'd1);
   endtask
   initial begin
      // reset state, then bypass works even while held in reset
      #1;
      check("rst_ready_lat0", 64'(ready_o), 64'd1);
      ready_i = 1'b0;
      #1;
      check("rst_ready_follows", 64'(ready_o), 64'd0);
      ready_i = 1'b1;
      lat_i   = 4'd2;
      #1;
      check_reset_outputs("rst");
      lat_i   = '0;
      valid_i = 1'b1;
      data_i  = 32'h0000_0005;
      #1;
      check("rst_bypass_valid", 64'(valid_o), 64'd1);
      check("rst_bypass_data", 64'(data_o), 64'h5);
      valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      // bypass
      step(1'b1, 0, 32'hA5A5_0001, 1'b1, 1'b0);
      idle(1, 1'b1);
      // single latency
      step(1'b1, 3, 32'h11, 1'b1, 1'b0);
      idle(5, 1'b1);
      // in-order with mixed latency
      step(1'b1, 5, 32'h1, 1'b1, 1'b0);
      step(1'b1, 1, 32'h2, 1'b1, 1'b0);
      idle(7, 1'b1);
      // full and backpressure
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1, 32'h100 + 32'(i), 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b1, 1, 32'h1FF, 1'b1, 1'b0);
      idle(6, 1'b1);
      // stall stability
      step(1'b1, 2, 32'hAA, 1'b0, 1'b0);
      step(1'b1, 1, 32'hBB, 1'b0, 1'b0);
      step(1'b1, 3, 32'hCC, 1'b0, 1'b0);
      idle(6, 1'b0);
      idle(4, 1'b1);
      // zero latency behind a busy head
      step(1'b1, 3, 32'hD0, 1'b1, 1'b0);
      step(1'b1, 0, 32'hD1, 1'b1, 1'b0);
      idle(5, 1'b1);
      // flush that collides with a push
      for (int i = 0; i < 3; i++) step(1'b1, 5, 32'hF0 + 32'(i), 1'b1, 1'b0);
      step(1'b1, 2, 32'h77, 1'b1, 1'b1);
      idle(8, 1'b1);
      // asynchronous reset mid-countdown
      for (int i = 0; i < 3; i++) step(1'b1, 6, 32'hE0 + 32'(i), 1'b1, 1'b0);
      idle(2, 1'b1);
      @(negedge clk_i);
      valid_i = 1'b0;
      lat_i   = 4'd3;
      #2 rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrst");
      q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(8, 1'b1);
      // random traffic
      for (int i = 0; i < 2000; i++)
         step(1'(($urandom_range(0, 99) < 60)), (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15))),
              $urandom, 1'(($urandom_range(0, 99) < 70)), 1'(($urandom_range(0, 99) < 3)));
      idle(20, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dummy_accelerator_lat_cu.md
# dummy_accelerator_lat_cu

Parametrised latency control unit for the dummy accelerator. It generalises the single-operation compute/wait control to up to DEPTH in-flight operations, each with its own programmable latency, and returns results strictly in order. It sits between the upstream issue interface and the downstream result interface. It stores operand data alongside per-slot countdowns so that new operations are accepted while earlier ones are still counting.

## Interface
- DATA_W, 32: width of the data payload carried per operation.
- DEPTH, 4: number of in-flight slots; power of two, ≥2.
- LAT_W, 4: width of the per-operation latency field.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; drops all in-flight operations.
- lat_i  in  LAT_W  latency of the operation presented with valid_i.
- data_i  in  DATA_W  operand/result payload of the presented operation.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DATA_W  result payload.
- valid_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- count_o  out  $clog2(DEPTH+1)  number of occupied slots.
- busy_o  out  1  count_o != 0.

## Operation
- Storage is a circular buffer of DEPTH slots. Each slot holds {data, remaining latency}. It has wr_ptr, rd_ptr and a count register.
- Accept happens when valid_i && ready_o && !flush_i. Cases:
  - If the buffer is empty and lat_i == 0, the operation takes the bypass path. valid_o = valid_i, data_o = data_i, and nothing is written.
  - Otherwise the slot at wr_ptr is written with data_i and a remaining value of max(lat_i−1, 0). wr_ptr advances modulo DEPTH.
- Countdown: every cycle, every occupied slot with a non-zero remaining value decrements by 1, saturating at 0. A slot written in this cycle starts decrementing from the next cycle.
- Output:
  - valid_o = occupied(head) && remaining(head) == 0, or the bypass case.
  - data_o = head data, or data_i when in bypass.
  - Pop happens on valid_o && ready_i (non-bypass). Pop advances rd_ptr modulo DEPTH.
- Completion is in order. A younger slot that reaches 0 while the head is non-zero stays at 0 and waits.
- ready_o:
  - When count < DEPTH: ready_o = 1, except when the buffer is empty and lat_i == 0, where ready_o = ready_i.
  - When the buffer is full: ready_o = 0, even if a pop is happening that cycle. ready_o never depends on valid_i.
- Push and pop in the same cycle leave the count unchanged.
- Downstream stall: while valid_o && !ready_i, valid_o and data_o stay stable. Younger countdowns keep running.
- Flush: while flush_i = 1, ready_o = 0 and valid_o = 0. On the next edge, count, wr_ptr and rd_ptr reset to 0. Slot contents are don't-care.

## Timing
- Reset values:
  - count_o = 0, busy_o = 0, valid_o = 0. The bypass still applies if valid_i is high with lat_i = 0.
  - ready_o = 1, or ready_i when lat_i == 0.
  - data_o = 0, with all slot data reset to 0.
- Latency for an operation accepted at edge t with lat_i = L ≥ 1 into an empty buffer: valid_o rises at cycle t+L.
- lat_i = 0 into an empty buffer is combinational, with zero cycles of latency.
- lat_i = 0 into a non-empty buffer is enqueued with remaining 0. It is valid as soon as it becomes head.
- Throughput: with L = 1 and ready_i held high, one result per cycle.
- Full buffer: ready_o is low for the cycle in which count == DEPTH. It rises the cycle after the first pop.
- A flush that arrives mid-operation or together with a push or pop always wins. No output appears for dropped operations.
- Reset mid-operation clears all state asynchronously. Outputs take their reset values immediately.

## Test plan
- Bypass: empty buffer, lat_i=0, data_i=0xA5A5_0001, ready_i=1. Required: valid_o and data_o=0xA5A5_0001 in the same cycle, and count_o stays 0.
- Single latency: lat_i=3 accepted at cycle 10 with data 0x11. Required: valid_o first high at cycle 13 with data_o=0x11, and count_o returns to 0 after the pop.
- In-order with mixed latency: issue lat 5 (0x1), then lat 1 (0x2) on consecutive cycles. Required: 0x1 at issue+5, then 0x2 on the next cycle, never reordered.
- Full and backpressure:
  - Setup: DEPTH=4, four ops with lat 1, ready_i=0.
  - Required: count_o=4 and ready_o=0.
  - Then raise ready_i: four results are popped in order, and ready_o rises the cycle after the first pop.
- Stall stability: head valid with ready_i=0 for 6 cycles. Required: data_o stays constant, and younger slots reach 0 and drain back-to-back afterwards.
- Flush and reset: 3 ops in flight, assert flush_i for 1 cycle. Required: count_o=0 the next cycle, and no valid_o for the dropped ops. Repeat with rst_ni pulsed low mid-countdown; all outputs must go to their reset values.
